// File: rtl/md_ctrl.sv
// ---------------------------------------------------------------------------
// md_ctrl
// Multiply/divide sequencer for the EX stage of the pipelined MIPS core.
// It sits beside the combinational ALU, owns the HI/LO registers and models
// the multi-cycle latency of mult/multu/div/divu with a down-counter. While
// an operation is outstanding it raises a stall request so that the hazard
// unit can hold any D-stage instruction that touches HI/LO.
//
// The 64-bit result is computed in the cycle the operation is accepted and
// parked in a pending register; HI/LO only change when the counter expires,
// so the architectural registers keep their old values for the whole busy
// window.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high reset
//   mdop      in   3   E-stage op: 000 none, 001 mult, 010 multu, 011 div,
//                      100 divu, 101 mthi, 110 mtlo, 111 none
//   data1_E   in  32   rs operand
//   data2_E   in  32   rt operand
//   md_req_D  in   1   D-stage instruction uses the mult/div unit or HI/LO
//   busy      out  1   operation in progress
//   start     out  1   a mult/div op is being accepted this cycle
//   hi        out 32   HI register
//   lo        out 32   LO register
//   md_stall  out  1   stall request for the D stage
// ---------------------------------------------------------------------------
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mdop,
    input  logic [31:0] data1_E,
    input  logic [31:0] data2_E,
    input  logic        md_req_D,
    output logic        busy,
    output logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    // Architectural and sequencing state.
    state_t      state_q,   state_d;
    logic [4:0]  count_q,   count_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    // Op decode.
    logic is_mult;
    logic is_div;
    logic is_md_op;

    // Datapath intermediates.
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    // Decode the E-stage op into the two operation classes that start a
    // multi-cycle sequence.
    always_comb begin
        is_mult  = (mdop == OP_MULT) || (mdop == OP_MULTU);
        is_div   = (mdop == OP_DIV)  || (mdop == OP_DIVU);
        is_md_op = is_mult || is_div;
    end

    // Multiplier: both operands are widened to 64 bits (sign- or zero-
    // extended depending on the op) so a single 64x64 multiply truncated to
    // 64 bits yields the correct product for both signed and unsigned forms.
    always_comb begin
        mul_a    = 64'(data1_E);
        mul_b    = 64'(data2_E);
        if (mdop == OP_MULT) begin
            mul_a = {{32{data1_E[31]}}, data1_E};
            mul_b = {{32{data2_E[31]}}, data2_E};
        end
        mul_prod = mul_a * mul_b;
    end

    // Divider: signed division is done on magnitudes and the signs are
    // reapplied afterwards, giving truncation toward zero and a remainder
    // that follows the dividend. Working on magnitudes also makes the
    // 0x80000000 / -1 case fall out naturally as 0x80000000 rem 0. A zero
    // divisor is replaced by one purely to keep the divider well defined;
    // that result is never committed.
    always_comb begin
        div_signed  = (mdop == OP_DIV);
        a_neg       = div_signed && data1_E[31];
        b_neg       = div_signed && data2_E[31];
        mag_a       = a_neg ? (~data1_E + 32'd1) : data1_E;
        mag_b       = b_neg ? (~data2_E + 32'd1) : data2_E;
        div_by_zero = (data2_E == 32'd0);
        safe_b      = div_by_zero ? 32'd1 : mag_b;
        uquot       = mag_a / safe_b;
        urem        = mag_a % safe_b;
        quot        = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
        rem         = a_neg ? (~urem + 32'd1) : urem;
    end

    // Select the result that will be parked in the pending registers and
    // whether it is allowed to reach HI/LO when the sequence completes.
    always_comb begin
        res_hi = mul_prod[63:32];
        res_lo = mul_prod[31:0];
        res_wr = 1'b1;
        if (is_div) begin
            res_hi = rem;
            res_lo = quot;
            res_wr = !div_by_zero;
        end
    end

    // Next-state logic. In IDLE a mult/div op loads the counter and the
    // pending result, while mthi/mtlo write their register directly. In RUN
    // every other op is ignored; the counter counts down and the pending
    // result is committed on the edge where the counter reaches one, which
    // also returns the block to IDLE so a new op can start the very next
    // cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        unique case (state_q)
            IDLE: begin
                if (is_md_op) begin
                    state_d   = RUN;
                    count_d   = is_mult ? MULT_LOAD : DIV_LOAD;
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = res_wr;
                end else if (mdop == OP_MTHI) begin
                    hi_d = data1_E;
                end else if (mdop == OP_MTLO) begin
                    lo_d = data1_E;
                end
            end
            RUN: begin
                count_d = count_q - 5'd1;
                if (count_q == 5'd1) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset wins over everything else and abandons any
    // operation in flight, including its pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Outputs. HI/LO come straight from flops; start and md_stall are
    // combinational so the hazard unit can hold D in the accept cycle.
    always_comb begin
        busy     = (state_q == RUN);
        start    = is_md_op && (state_q == IDLE);
        md_stall = md_req_D && (start || busy);
        hi       = hi_q;
        lo       = lo_q;
    end

endmodule

// File: tb/tb_md_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_ctrl
// Self-checking bench for md_ctrl. A behavioural model tracks remaining busy
// cycles and HI/LO using plain 64-bit arithmetic; directed sequences cover
// the interesting corner cases and a randomized phase exercises the rest.
// ---------------------------------------------------------------------------
module tb_md_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  mdop;
   logic [31:0] data1_E;
   logic [31:0] data2_E;
   logic        md_req_D;
   logic        busy;
   logic        start;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        md_stall;

   int total = 0;
   int bad   = 0;

   // Reference model state.
   int          mdlLeft  = 0;
   logic [31:0] mdlHi    = 32'd0;
   logic [31:0] mdlLo    = 32'd0;
   logic [31:0] mdlPendHi = 32'd0;
   logic [31:0] mdlPendLo = 32'd0;
   bit          mdlPendWr = 1'b0;
   bit          mdlValid  = 1'b0;
   logic        seenBusy;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   md_ctrl #(
      .MULT_CYCLES(MULT_N),
      .DIV_CYCLES (DIV_N)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .mdop    (mdop),
      .data1_E (data1_E),
      .data2_E (data2_E),
      .md_req_D(md_req_D),
      .busy    (busy),
      .start   (start),
      .hi      (hi),
      .lo      (lo),
      .md_stall(md_stall)
   );

   // The hazard unit never issues a mult/div/mthi/mtlo while the unit is busy.
   always @(posedge clk) begin
      if (!reset && busy && (mdop inside {[3'd1:3'd6]}))
         $error("[TB] md op %0d issued while busy", mdop);
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance the model across one rising edge with the inputs that were
   // applied in the preceding cycle.
   task automatic modelEdge(input logic rst, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (rst) begin
         mdlLeft = 0; mdlHi = 32'd0; mdlLo = 32'd0;
         mdlPendHi = 32'd0; mdlPendLo = 32'd0; mdlPendWr = 1'b0;
         mdlValid = 1'b1;
      end else if (mdlLeft > 0) begin
         mdlLeft--;
         if (mdlLeft == 0 && mdlPendWr) begin
            mdlHi = mdlPendHi;
            mdlLo = mdlPendLo;
         end
      end else begin
         case (op)
            3'd1: begin
               p = 64'(sa * sb);
               mdlPendHi = p[63:32]; mdlPendLo = p[31:0]; mdlPendWr = 1'b1; mdlLeft = MULT_N;
            end
            3'd2: begin
               p = ua * ub;
               mdlPendHi = p[63:32]; mdlPendLo = p[31:0]; mdlPendWr = 1'b1; mdlLeft = MULT_N;
            end
            3'd3: begin
               mdlLeft = DIV_N;
               mdlPendWr = (b != 32'd0);
               if (b != 32'd0) begin
                  q = sa / sb;
                  r = sa % sb;
                  mdlPendLo = q[31:0]; mdlPendHi = r[31:0];
               end
            end
            3'd4: begin
               mdlLeft = DIV_N;
               mdlPendWr = (b != 32'd0);
               if (b != 32'd0) begin
                  p = ua / ub;
                  mdlPendLo = p[31:0];
                  p = ua % ub;
                  mdlPendHi = p[31:0];
               end
            end
            3'd5: mdlHi = a;
            3'd6: mdlLo = a;
            default: ;
         endcase
      end
   endtask

   // Drive one cycle of inputs (called just after a falling edge), compare
   // every output against the model, then step through the rising edge.
   task automatic applyStimulus(input logic rst, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic req);
      bit expBusy, expStart, expStall;
      reset = rst; mdop = op; data1_E = a; data2_E = b; md_req_D = req;
      #1;
      expBusy  = (mdlLeft > 0);
      expStart = !expBusy && (op inside {[3'd1:3'd4]});
      expStall = req && (expStart || expBusy);
      if (mdlValid) begin
         checkOutput("busy",  64'(busy),     64'(expBusy));
         checkOutput("start", 64'(start),    64'(expStart));
         checkOutput("stall", 64'(md_stall), 64'(expStall));
         checkOutput("hi",    64'(hi),       64'(mdlHi));
         checkOutput("lo",    64'(lo),       64'(mdlLo));
      end
      seenBusy = busy;
      @(posedge clk);
      modelEdge(rst, op, a, b);
      @(negedge clk);
   endtask

   // Idle the inputs until busy drops, returning how many busy cycles were seen.
   task automatic runUntilIdle(input logic req, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, req);
         if (!seenBusy) break;
         n++;
      end
      checkOutput("idle_reached", 64'(seenBusy), 64'd0);
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int n;
      logic [2:0]  op;
      logic [31:0] a, b;
      reset = 1'b1; mdop = 3'd0; data1_E = 32'd0; data2_E = 32'd0; md_req_D = 1'b0;
      @(negedge clk);
      applyStimulus(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
      applyStimulus(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_hi",   64'(hi),   64'd0);
      checkOutput("rst_lo",   64'(lo),   64'd0);

      // Reset in the third busy cycle of a div aborts it and clears HI/LO.
      applyStimulus(1'b0, 3'd5, 32'h0000_AAAA, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'd6, 32'h0000_BBBB, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      applyStimulus(1'b1, 3'd0, 32'd0, 32'd0, 1'b0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_hi",   64'(hi),   64'd0);
      checkOutput("midrst_lo",   64'(lo),   64'd0);

      // mult with the D stage waiting on HI/LO.
      applyStimulus(1'b0, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
      runUntilIdle(1'b1, n);
      checkOutput("mult_len", 64'(n),  64'(MULT_N));
      checkOutput("mult_hi",  64'(hi), 64'hFFFF_FFFF);
      checkOutput("mult_lo",  64'(lo), 64'hFFFF_FFFE);

      // multu, independent instruction in D so no stall.
      applyStimulus(1'b0, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
      runUntilIdle(1'b0, n);
      checkOutput("multu_len", 64'(n),  64'(MULT_N));
      checkOutput("multu_hi",  64'(hi), 64'h0000_0001);
      checkOutput("multu_lo",  64'(lo), 64'hFFFF_FFFE);

      // Back-to-back: second mult issued in the cycle busy falls.
      applyStimulus(1'b0, 3'd1, 32'd3, 32'd4, 1'b1);
      repeat (MULT_N) applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b0, 3'd1, 32'd6, 32'd7, 1'b1);
      checkOutput("b2b_busy", 64'(busy), 64'd1);
      checkOutput("b2b_lo1",  64'(lo),   64'd12);
      runUntilIdle(1'b0, n);
      checkOutput("b2b_lo2",  64'(lo),   64'd42);

      // Signed division of a negative dividend.
      applyStimulus(1'b0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      runUntilIdle(1'b0, n);
      checkOutput("div_len", 64'(n),  64'(DIV_N));
      checkOutput("div_hi",  64'(hi), 64'hFFFF_FFFF);
      checkOutput("div_lo",  64'(lo), 64'hFFFF_FFFD);

      // Divide by zero leaves HI/LO as written by mthi/mtlo.
      applyStimulus(1'b0, 3'd5, 32'h0000_1234, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'd6, 32'h0000_5678, 32'd0, 1'b0);
      applyStimulus(1'b0, 3'd4, 32'd7, 32'd0, 1'b0);
      runUntilIdle(1'b0, n);
      checkOutput("div0_len", 64'(n),  64'(DIV_N));
      checkOutput("div0_hi",  64'(hi), 64'h0000_1234);
      checkOutput("div0_lo",  64'(lo), 64'h0000_5678);

      // Most-negative divided by minus one.
      applyStimulus(1'b0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      runUntilIdle(1'b0, n);
      checkOutput("ovf_hi", 64'(hi), 64'h0);
      checkOutput("ovf_lo", 64'(lo), 64'h8000_0000);

      // Randomized phase; only 000/111 are driven while the model is busy.
      for (int i = 0; i < 600; i++) begin
         if (mdlLeft > 0) op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
         else             op = 3'($urandom_range(0, 7));
         a = pickOperand();
         b = pickOperand();
         applyStimulus(($urandom_range(0, 99) == 0), op, a, b, 1'($urandom_range(0, 1)));
      end
      runUntilIdle(1'b1, n);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer for the EX stage of the pipelined MIPS core; sits beside the combinational ALU and takes the same E-stage operands (rs in data1_E, rt in data2_E).
- Owns the HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- Generates the stall request that the hazard unit uses to hold the D stage while HI/LO are unavailable.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (1..31).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (1..31).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mdop  input  3  E-stage op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- data1_E  input  32  rs operand.
- data2_E  input  32  rt operand.
- md_req_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in progress.
- start  output  1  combinational; mdop is 001..100 and the block is IDLE.
- hi  output  32  HI register.
- lo  output  32  LO register.
- md_stall  output  1  combinational: md_req_D & (start | busy).

Behaviour:
- Reset (sync, active-high): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result cleared. Reset aborts any operation in progress.
- Reset dominates every other input in the same cycle.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Accepting an op:
  - In IDLE, mdop 001..100 at a rising edge latches the operands and computes the 64-bit result into pending_hi/pending_lo.
  - counter loads MULT_CYCLES or DIV_CYCLES; state moves to RUN.
  - busy is 1 starting the next cycle.
- RUN:
  - counter decrements each edge.
  - On the edge where counter==1: hi/lo <= pending values, busy goes 0, state returns to IDLE.
  - busy is therefore high for exactly N cycles. New hi/lo are visible in the first cycle with busy=0.
- Back-to-back: a new start is accepted in the same cycle busy falls (state is IDLE that cycle). No idle gap is required.
- mdop 001..110 while busy is ignored. The hazard unit guarantees this cannot occur; the bench flags it as an assertion.
- mthi/mtlo in IDLE: hi (or lo) <= data1_E at the edge, one-cycle write, busy stays 0. The other register is unchanged.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 -> 64.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (no trap).
  - Divisor == 0 (div or divu): busy still runs DIV_CYCLES; hi/lo are NOT updated at completion.
- md_stall:
  - Asserted in the cycle a start is issued (start=1) and in every busy cycle, whenever md_req_D=1.
  - Never asserted when md_req_D=0, so independent instructions continue.
- Outputs hi/lo are registered. No combinational path from the inputs to hi/lo.

Test Plan:
- Reset mid-op: reset in cycle 3 of a div -> next cycle busy=0, hi=0, lo=0. A following mult starts normally.
- mult 0xFFFFFFFF, 0x00000002 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. hi/lo hold their old values during busy.
- multu same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
- div 0xFFFFFFF9 (-7), 0x00000002 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 0x7, 0x0 after mthi 0x1234/mtlo 0x5678 -> busy 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
- Stall/back-to-back: mult issued with md_req_D=1 -> md_stall=1 for start cycle + 5 busy cycles, 0 when busy falls. md_req_D=0 during busy -> md_stall=0. A second mult issued in the cycle busy falls is accepted.
